// File: rtl/bit_diff_pkg.sv
// Shared types for the bit-difference feeder and the engine it drives.
package bit_diff_pkg;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2
    } feeder_state_e;

    typedef struct packed {
        logic go;
        logic done;
    } engine_hs_t;

    function automatic logic word_parity(input logic [63:0] word);
        return ^word;
    endfunction

endpackage

// File: rtl/bit_diff_fifo.sv
// Circular word FIFO for the feeder: DEPTH entries (power of 2), head always visible.
module bit_diff_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push,
    input  logic [WIDTH-1:0]             push_data,
    input  logic                         pop,
    output logic [WIDTH-1:0]             head,
    output logic [$clog2(DEPTH+1)-1:0]   count,
    output logic                         full
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = $clog2(DEPTH+1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [AW-1:0]    r_wr_ptr;
    logic [AW-1:0]    r_rd_ptr;
    logic [CW-1:0]    r_count;
    logic             w_push;
    logic             w_pop;

    assign full   = (r_count == CW'(DEPTH));
    assign w_push = push && !full;
    assign w_pop  = pop && (r_count != {CW{1'b0}});
    assign head   = r_mem[r_rd_ptr];
    assign count  = r_count;

    // Pointers wrap naturally because DEPTH is a power of 2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_wr_ptr <= {AW{1'b0}};
            r_rd_ptr <= {AW{1'b0}};
        end else begin
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + AW'(1);
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + AW'(1);
            end
        end
    end

    // Occupancy: simultaneous push and pop leaves it unchanged.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_count <= {CW{1'b0}};
        end else begin
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Storage array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                r_mem[i] <= {WIDTH{1'b0}};
            end
        end else if (w_push) begin
            r_mem[r_wr_ptr] <= push_data;
        end
    end

endmodule

// File: rtl/bit_diff_feeder.sv
// Feeds queued words one at a time to a bit-difference engine with a sticky done.
// Optional macro BIT_DIFF_FEEDER_STATS_EN adds a 32-bit issued_cnt output.
module bit_diff_feeder
    import bit_diff_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [WIDTH-1:0]             in_data,
    output logic                         go,
    output logic [WIDTH-1:0]             data,
    input  logic                         done,
    output logic                         busy,
    output logic [$clog2(DEPTH+1)-1:0]   count
`ifdef BIT_DIFF_FEEDER_STATS_EN
    ,
    output logic [31:0]                  issued_cnt
`endif
);
    localparam int CW = $clog2(DEPTH+1);

    feeder_state_e    r_state;
    feeder_state_e    w_next_state;
    logic             r_go;
    logic             r_busy;
    logic             r_done_d;
    logic [WIDTH-1:0] r_data;
    logic [WIDTH-1:0] w_head;
    logic [CW-1:0]    w_count;
    logic             w_full;
    logic             w_push;
    logic             w_pop;
    logic             w_load;
    logic             w_done_rise;

    bit_diff_fifo #(
        .WIDTH (WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (w_push),
        .push_data (in_data),
        .pop       (w_pop),
        .head      (w_head),
        .count     (w_count),
        .full      (w_full)
    );

    assign in_ready    = !w_full;
    assign w_push      = in_valid && !w_full;
    assign w_done_rise = done && !r_done_d;
    assign go          = r_go;
    assign data        = r_data;
    assign busy        = r_busy;
    assign count       = w_count;

    // State register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_next_state;
        end
    end

    // Next-state, head load and pop decisions.
    always_comb begin
        w_next_state = r_state;
        w_load       = 1'b0;
        w_pop        = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_count != {CW{1'b0}}) begin
                    w_load       = 1'b1;
                    w_next_state = ISSUE;
                end else begin
                    w_next_state = IDLE;
                end
            end
            ISSUE: begin
                w_next_state = WAIT;
            end
            WAIT: begin
                // A done still high from the previous word has no rising edge, so it is ignored.
                if (w_done_rise) begin
                    w_pop        = 1'b1;
                    w_next_state = IDLE;
                end else begin
                    w_next_state = WAIT;
                end
            end
            default: begin
                w_next_state = IDLE;
            end
        endcase
    end

    // Registered engine-facing outputs; go is high exactly for the ISSUE cycle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_go     <= 1'b0;
            r_busy   <= 1'b0;
            r_data   <= {WIDTH{1'b0}};
            r_done_d <= 1'b0;
        end else begin
            r_go     <= w_load;
            r_done_d <= done;
            if (w_load) begin
                r_data <= w_head;
                r_busy <= 1'b1;
            end else if (w_pop) begin
                r_busy <= 1'b0;
            end else begin
                r_busy <= r_busy;
            end
        end
    end

`ifdef BIT_DIFF_FEEDER_STATS_EN
    logic [31:0] r_issued_cnt;

    // Count of go pulses, wrapping at 2^32.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_issued_cnt <= 32'd0;
        end else if (r_go) begin
            r_issued_cnt <= r_issued_cnt + 32'd1;
        end
    end

    assign issued_cnt = r_issued_cnt;
`endif

endmodule

// File: tb/tb_bit_diff_feeder.sv
// Scoreboard bench for bit_diff_feeder: pushed words are queued, a monitor checks each go.
module tb_bit_diff_feeder;
    localparam int WIDTH = 8;
    localparam int DEPTH = 4;
    localparam int CW    = $clog2(DEPTH+1);

    logic             clk = 1'b0;
    logic             rst_n;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] in_data;
    logic             go;
    logic [WIDTH-1:0] data;
    logic             done;
    logic             busy;
    logic [CW-1:0]    count;
`ifdef BIT_DIFF_FEEDER_STATS_EN
    logic [31:0]      issued_cnt;
`endif

    int               checks = 0;
    int               errors = 0;
    int               go_seen = 0;
    logic [WIDTH-1:0] exp_q[$];
    logic [WIDTH-1:0] last_data = '0;

    always #5 clk = ~clk;

    bit_diff_feeder #(.WIDTH(WIDTH), .DEPTH(DEPTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .in_data    (in_data),
        .go         (go),
        .data       (data),
        .done       (done),
        .busy       (busy),
        .count      (count)
`ifdef BIT_DIFF_FEEDER_STATS_EN
        ,
        .issued_cnt (issued_cnt)
`endif
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Monitor: every go must carry the oldest outstanding word; data must hold while busy.
    always @(negedge clk) begin
        if (rst_n && go) begin
            go_seen++;
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_go: got go with data %0h, expected no go", data);
            end else begin
                check("go_data", 32'(data), 32'(exp_q.pop_front()));
                check("go_busy", 32'(busy), 32'd1);
            end
            last_data = data;
        end else if (rst_n && busy) begin
            check("data_stable", 32'(data), 32'(last_data));
        end
    end

    // Called at a negedge; returns at the negedge after the word was accepted.
    task automatic push(input logic [WIDTH-1:0] d);
        int n = 0;
        in_valid = 1'b1;
        in_data  = d;
        while (!in_ready && n < 200) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL push_timeout: in_ready stayed %0b, expected 1", in_ready);
        end else begin
            exp_q.push_back(d);
        end
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    // Engine model: drops done on go, raises it 10 cycles later.
    task automatic engine(input int n_words);
        for (int k = 0; k < n_words; k++) begin
            int w = 0;
            while (!go && w < 200) begin
                @(negedge clk);
                w++;
            end
            if (!go) begin
                checks++;
                errors++;
                $display("FAIL engine_wait_go: go=%0b after %0d cycles, expected 1", go, w);
                return;
            end
            done = 1'b0;
            repeat (10) @(negedge clk);
            done = 1'b1;
            @(negedge clk);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time expired, expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int go_before;
        rst_n    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        done     = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_go",       32'(go),       32'd0);
        check("rst_busy",     32'(busy),     32'd0);
        check("rst_count",    32'(count),    32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd1);
        check("rst_data",     32'(data),     32'd0);
        rst_n = 1'b1;
        @(negedge clk);

        // Single word: go two cycles after the push cycle.
        push(8'hA5);
        check("lat_go_early", 32'(go),    32'd0);
        check("lat_count",    32'(count), 32'd1);
        @(negedge clk);
        check("lat_go",       32'(go),    32'd1);
        check("lat_data",     32'(data),  32'hA5);
        check("lat_busy",     32'(busy),  32'd1);
        @(negedge clk);
        check("wait_go_low",  32'(go),    32'd0);
        check("wait_busy",    32'(busy),  32'd1);
        done = 1'b1;
        @(negedge clk);
        check("pop_busy",     32'(busy),  32'd0);
        check("pop_count",    32'(count), 32'd0);

        // Fill to DEPTH while done stays sticky-high; the fifth word is held off.
        push(8'h11);
        push(8'h22);
        push(8'h33);
        push(8'h44);
        check("full_count", 32'(count), 32'd4);
        in_valid = 1'b1;
        in_data  = 8'h55;
        check("full_in_ready", 32'(in_ready), 32'd0);
        repeat (3) @(negedge clk);
        check("sticky_no_pop",  32'(count), 32'd4);
        check("sticky_busy",    32'(busy),  32'd1);
        done = 1'b0;
        repeat (2) @(negedge clk);
        check("low_no_pop",     32'(count), 32'd4);
        done = 1'b1;
        @(negedge clk);
        check("full_pushpop_count", 32'(count),    32'd3);
        check("rise_pop_busy",      32'(busy),     32'd0);
        check("rise_in_ready",      32'(in_ready), 32'd1);
        in_valid = 1'b0;
        @(negedge clk);
        @(negedge clk);
        check("wait3_count", 32'(count), 32'd3);
        check("wait3_busy",  32'(busy),  32'd1);

        // Asynchronous reset in WAIT discards everything.
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_go",       32'(go),       32'd0);
        check("arst_busy",     32'(busy),     32'd0);
        check("arst_count",    32'(count),    32'd0);
        check("arst_in_ready", 32'(in_ready), 32'd1);
        check("arst_data",     32'(data),     32'd0);
        exp_q.delete();
        go_before = go_seen;
        @(negedge clk);
        rst_n = 1'b1;
        done  = 1'b0;
        repeat (20) @(negedge clk);
        check("arst_no_go",    32'(go_seen - go_before), 32'd0);
        check("arst_count2",   32'(count),               32'd0);

        // Stream 16 words through a 10-cycle engine; pointers wrap several times.
        go_before = go_seen;
        fork
            begin
                for (int k = 0; k < 16; k++) begin
                    push(8'(8'h3C ^ (k * 17)));
                end
            end
            engine(16);
        join
        repeat (3) @(negedge clk);
        check("stream_go_count", 32'(go_seen - go_before), 32'd16);
        check("stream_q_empty",  32'(exp_q.size()),       32'd0);
        check("stream_count",    32'(count),               32'd0);
        check("stream_busy",     32'(busy),                32'd0);
`ifdef BIT_DIFF_FEEDER_STATS_EN
        check("issued_cnt",      issued_cnt,               32'd16);
`endif

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/bit_diff_feeder.md
BIT_DIFF_FEEDER -- requirements
Module: bit_diff_feeder

Interface
REQ-001 SHALL have parameter WIDTH, default 8: bit width of each data word.
REQ-002 SHALL have parameter DEPTH, default 4: FIFO entries; power of 2, at least 2.
REQ-003 SHALL have port clk, input, 1 bit: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst_n, input, 1 bit: reset, asynchronous, active-low.
REQ-005 SHALL have port in_valid, input, 1 bit: upstream word present.
REQ-006 SHALL have port in_ready, output, 1 bit: feeder accepts a word this cycle.
REQ-007 SHALL have port in_data, input, WIDTH bits: upstream word.
REQ-008 SHALL have port go, output, 1 bit: start pulse to the downstream bit-difference engine.
REQ-009 SHALL have port data, output, WIDTH bits: word presented to the engine.
REQ-010 SHALL have port done, input, 1 bit: engine level-done; stays high until the engine's next go.
REQ-011 SHALL have port busy, output, 1 bit: a word is in flight in the engine.
REQ-012 SHALL have port count, output, $clog2(DEPTH+1) bits: current FIFO occupancy.

Function
REQ-013 SHALL accept a word on any rising edge where in_valid and in_ready are both high; in_ready = (count != DEPTH), combinational from registered occupancy only.
REQ-014 SHALL implement FSM states IDLE, ISSUE and WAIT.
REQ-015 In IDLE with count > 0, SHALL load data with the FIFO head word and move to ISSUE next cycle.
REQ-016 In ISSUE, SHALL drive go high for exactly one cycle, set busy, and move to WAIT.
REQ-017 In WAIT, SHALL keep go low and data stable; SHALL detect the done rising edge (done high, previous-cycle done low), then pop the head, clear busy and return to IDLE.
REQ-018 SHALL ignore a done that is already high on WAIT entry until it has been seen low; this handles the engine's sticky done.
REQ-019 Latency from the first word written into an empty FIFO while IDLE to go high SHALL be 2 cycles.
REQ-020 A push and a pop in the same cycle SHALL leave count unchanged and keep both words correct.
REQ-021 When full, a push in the same cycle as a pop SHALL NOT be accepted, because in_ready is low.
REQ-022 Read and write pointers SHALL wrap modulo DEPTH without loss or duplication.
REQ-023 data SHALL be a register and SHALL change only on the IDLE-to-ISSUE transition.

Reset
REQ-024 Asserting rst_n low SHALL immediately set the state to IDLE, go=0, data=0, busy=0, count=0, pointers=0, and the done-history bit=0; in_ready SHALL then read 1.
REQ-025 Reset during ISSUE or WAIT SHALL discard the in-flight word and all queued words; no go is issued until a new word arrives.

Configuration
REQ-026 With macro BIT_DIFF_FEEDER_STATS_EN defined, the block SHALL add an output issued_cnt, 32 bits, that increments on every go pulse, wraps at 2^32, and resets to 0.
REQ-027 Without BIT_DIFF_FEEDER_STATS_EN, issued_cnt and its logic SHALL be absent; all other behaviour SHALL be identical.

Structure
REQ-028 The FSM state enum (IDLE, ISSUE, WAIT) SHALL live in shared package bit_diff_pkg, alongside the engine's types.
REQ-029 The FIFO storage and pointers SHALL be a sub-module bit_diff_fifo, parameterised by WIDTH and DEPTH, exposing push, pop, head, count and full.
REQ-030 Total RTL SHALL be 120-400 lines.

Verification
REQ-031 Reset with in_valid=0 -> go=0, busy=0, count=0, in_ready=1, data=0.
REQ-032 Push 8'hA5 with WIDTH=8 into an empty FIFO while IDLE -> go high 2 cycles later with data=8'hA5; busy=1.
REQ-033 Push 5 words with DEPTH=4 while the engine does not raise done -> 4 words accepted, in_ready=0, count=4; the fifth is held by upstream.
REQ-034 done held high from the previous word when WAIT is entered -> no pop until done goes low and then high again; a single pop follows.
REQ-035 Stream 16 words back-to-back with a model engine (done rises 10 cycles after go) -> 16 go pulses, data sequence in push order, pointer wrap exercised; with BIT_DIFF_FEEDER_STATS_EN defined, issued_cnt=16.
REQ-036 rst_n asserted low during WAIT with count=3 -> all outputs return to reset values immediately, and no go occurs until a new word is pushed.
